// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared types for the digit-serial ALU.
//   op_t    : operation select (SUM, AND, OR, XOR), matches the 2-bit op port
//   state_t : sequencing states of the serial controller
package alu_serial_pkg;

    typedef enum logic [1:0] {
        OP_SUM = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_serial_digit.sv
// alu_digit: combinational DIGIT-wide ALU slice.
//   a, eb     : operand A digit and effective-B digit
//   cy_in     : carry into the slice LSB
//   op        : operation select
//   s         : result digit
//   cy_out    : carry out of the slice MSB
//   cy_msb_in : carry into the slice MSB (for signed-overflow detection)
module alu_digit
    import alu_serial_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] eb,
    input  logic             cy_in,
    input  op_t              op,
    output logic [DIGIT-1:0] s,
    output logic             cy_out,
    output logic             cy_msb_in
);

    logic w_c;

    // Carry ripples through every bit regardless of op; the top-level
    // gates the carry-derived flags to SUM only.
    always_comb begin
        w_c       = cy_in;
        s         = '0;
        cy_msb_in = 1'b0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                cy_msb_in = w_c;
            end
            case (op)
                OP_SUM:  s[i] = a[i] ^ eb[i] ^ w_c;
                OP_AND:  s[i] = a[i] & eb[i];
                OP_OR:   s[i] = a[i] | eb[i];
                OP_XOR:  s[i] = a[i] ^ eb[i];
                default: s[i] = 1'b0;
            endcase
            w_c = (a[i] & eb[i]) | (w_c & (a[i] ^ eb[i]));
        end
        cy_out = w_c;
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU, WIDTH bits processed DIGIT bits per clock,
// LSB digit first, carry registered between digits.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operation request handshake
//   a, b, op              : operands and operation (00 SUM, 01 AND, 10 OR, 11 XOR)
//   b_inv, b_zero         : effective B = (b_zero ? 0 : b) ^ {WIDTH{b_inv}}
//   carry_in              : carry into bit 0 (SUM only)
//   out_valid / out_ready : result handshake
//   result, flag_c/z/n/v  : result and carry/zero/negative/overflow flags
//   busy                  : operation in progress or result pending
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             b_inv,
    input  logic             b_zero,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    op_t              r_op;
    logic             r_cy;
    logic             r_zacc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_fc;
    logic             r_fz;
    logic             r_fn;
    logic             r_fv;

    logic [WIDTH-1:0] w_eb;
    logic [DIGIT-1:0] w_s;
    logic             w_cy_out;
    logic             w_cy_msb_in;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_is_sum;

    assign w_eb   = (b_zero ? '0 : b) ^ {WIDTH{b_inv}};
    assign w_last = (r_cnt == CW'(NDIG - 1));
    // New digit enters at the MSB end; written as shift+OR so DIGIT==WIDTH
    // needs no special-case slice.
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
    assign w_is_sum   = (r_op == OP_SUM);

    alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a         (r_a[DIGIT-1:0]),
        .eb        (r_b[DIGIT-1:0]),
        .cy_in     (r_cy),
        .op        (r_op),
        .s         (w_s),
        .cy_out    (w_cy_out),
        .cy_msb_in (w_cy_msb_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_op     <= OP_SUM;
            r_cy     <= 1'b0;
            r_zacc   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_fc     <= 1'b0;
            r_fz     <= 1'b0;
            r_fn     <= 1'b0;
            r_fv     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= w_eb;
                        r_op   <= op_t'(op);
                        r_cy   <= carry_in;
                        r_zacc <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_a    <= r_a >> DIGIT;
                    r_b    <= r_b >> DIGIT;
                    r_acc  <= w_acc_next;
                    r_cy   <= w_cy_out;
                    r_zacc <= r_zacc | (|w_s);
                    r_cnt  <= r_cnt + CW'(1);
                    // Outputs change only here, so a partial result is never visible.
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_fc     <= w_is_sum & w_cy_out;
                        r_fz     <= ~(r_zacc | (|w_s));
                        r_fn     <= w_acc_next[WIDTH-1];
                        r_fv     <= w_is_sum & (w_cy_out ^ w_cy_msb_in);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;
    assign flag_c    = r_fc;
    assign flag_z    = r_fz;
    assign flag_n    = r_fn;
    assign flag_v    = r_fv;

endmodule
